// File: rtl/roce_stack_dm_status_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module : roce_stack_dm_status_tracker_pkg
// Brief  : Datamover command/status views and pending-entry type shared by
//          the datamover status tracker.
// Rev    : 1.0
// ============================================================================
package roce_stack_dm_status_tracker_pkg;

    localparam int DM_BTT_W = 23;
    localparam int DM_TAG_W = 4;
    localparam int DM_QPN_W = 16;
    localparam int DM_CMD_W = 104;

    typedef struct packed {
        logic                okay;
        logic                slverr;
        logic                decerr;
        logic                interr;
        logic [DM_TAG_W-1:0] tag;
    } dm_sts_t;

    typedef struct packed {
        logic [3:0]          rsvd;
        logic [DM_TAG_W-1:0] tag;
        logic [63:0]         addr;
        logic [8:0]          ctrl;
        logic [DM_BTT_W-1:0] btt;
    } dm_cmd_t;

    typedef struct packed {
        logic [DM_TAG_W-1:0] tag;
        logic [DM_BTT_W-1:0] btt;
        logic [DM_QPN_W-1:0] qpn;
    } dm_pend_t;

    localparam int DM_PEND_W = $bits(dm_pend_t);

    // {tag_mismatch, SLVERR, DECERR, INTERR}
    function automatic logic [3:0] dm_err_code(input dm_pend_t e, input dm_sts_t s);
        return {(e.tag != s.tag), s.slverr, s.decerr, s.interr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/roce_stack_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : roce_stack_sync_fifo
// Brief  : Single-clock FIFO with extra pointer MSB for full/empty and count.
// Rev    : 1.0
// ============================================================================
module roce_stack_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/roce_stack_dm_status_tracker.sv
`default_nettype none
// ============================================================================
// Module : roce_stack_dm_status_tracker
// Brief  : Matches datamover status beats to snooped commands, emits RoCE
//          completion records and keeps sticky error/event counters.
// Rev    : 1.0
// ============================================================================
module roce_stack_dm_status_tracker
    import roce_stack_dm_status_tracker_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     axis_aclk_i,
    input  logic                     aresetn_i,
    input  logic                     cmd_valid_i,
    input  logic                     cmd_ready_i,
    input  logic [DM_CMD_W-1:0]      cmd_data_i,
    input  logic [DM_QPN_W-1:0]      cmd_qpn_i,
    output logic                     cmd_allow_o,
    input  logic                     sts_tvalid_i,
    output logic                     sts_tready_o,
    input  logic [7:0]               sts_tdata_i,
    input  logic                     sts_tkeep_i,
    input  logic                     sts_tlast_i,
    output logic                     cpl_valid_o,
    input  logic                     cpl_ready_i,
    output logic [DM_QPN_W-1:0]      cpl_qpn_o,
    output logic [DM_BTT_W-1:0]      cpl_bytes_o,
    output logic [DM_TAG_W-1:0]      cpl_tag_o,
    output logic                     cpl_err_o,
    output logic [3:0]               cpl_err_code_o,
    output logic [$clog2(DEPTH):0]   outstanding_o,
    output logic [CNT_W-1:0]         cpl_cnt_o,
    output logic [15:0]              err_cnt_o,
    output logic                     orphan_o,
    output logic                     err_o,
    input  logic                     err_clr_i
);

    logic                    w_rst;
    dm_cmd_t                 w_cmd;
    dm_sts_t                 w_sts;
    dm_pend_t                w_push_entry;
    dm_pend_t                w_head;
    logic [DM_PEND_W-1:0]    w_head_raw;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_orphan;
    logic                    w_deliver;
    logic [3:0]              w_err_code;
    logic [1:0]              w_err_inc;
    logic [16:0]             w_err_sum;
    logic                    w_unused;

    logic                    r_cpl_valid;
    logic [DM_QPN_W-1:0]     r_cpl_qpn;
    logic [DM_BTT_W-1:0]     r_cpl_bytes;
    logic [DM_TAG_W-1:0]     r_cpl_tag;
    logic                    r_cpl_err;
    logic [3:0]              r_cpl_code;
    logic [CNT_W-1:0]        r_cpl_cnt;
    logic [15:0]             r_err_cnt;
    logic                    r_orphan;
    logic                    r_err;

    assign w_rst        = ~aresetn_i;
    assign w_cmd        = dm_cmd_t'(cmd_data_i);
    assign w_sts        = dm_sts_t'(sts_tdata_i);
    assign w_push_entry = '{tag: w_cmd.tag, btt: w_cmd.btt, qpn: cmd_qpn_i};
    assign w_head       = dm_pend_t'(w_head_raw);
    assign w_unused     = ^{w_cmd.rsvd, w_cmd.addr, w_cmd.ctrl, sts_tkeep_i, sts_tlast_i};

    assign cmd_allow_o  = ~w_full;
    assign sts_tready_o = ~r_cpl_valid | cpl_ready_i;
    assign w_push       = cmd_valid_i & cmd_ready_i & cmd_allow_o;
    assign w_accept     = sts_tvalid_i & sts_tready_o;
    assign w_pop        = w_accept & ~w_empty;
    assign w_orphan     = w_accept &  w_empty;
    assign w_deliver    = r_cpl_valid & cpl_ready_i;
    assign w_err_code   = dm_err_code(w_head, w_sts);

    // An orphan and an erroneous delivery can land in the same cycle.
    assign w_err_inc    = {1'b0, w_deliver & r_cpl_err} + {1'b0, w_orphan};
    assign w_err_sum    = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    roce_stack_sync_fifo #(
        .WIDTH (DM_PEND_W),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk       (axis_aclk_i),
        .rst       (w_rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head_raw),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (outstanding_o)
    );

    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            r_cpl_valid <= 1'b0;
            r_cpl_qpn   <= '0;
            r_cpl_bytes <= '0;
            r_cpl_tag   <= '0;
            r_cpl_err   <= 1'b0;
            r_cpl_code  <= '0;
            r_cpl_cnt   <= '0;
            r_err_cnt   <= '0;
            r_orphan    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cpl_valid <= 1'b1;
                r_cpl_qpn   <= w_head.qpn;
                r_cpl_bytes <= w_head.btt;
                r_cpl_tag   <= w_sts.tag;
                r_cpl_code  <= w_err_code;
                r_cpl_err   <= (|w_err_code) | ~w_sts.okay;
            end else if (w_deliver) begin
                r_cpl_valid <= 1'b0;
            end

            if (w_deliver) r_cpl_cnt <= r_cpl_cnt + CNT_W'(1);
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

            if (err_clr_i) begin
                r_orphan <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                if (w_orphan)                            r_orphan <= 1'b1;
                if (w_orphan | (w_deliver & r_cpl_err))  r_err    <= 1'b1;
            end
        end
    end

    assign cpl_valid_o    = r_cpl_valid;
    assign cpl_qpn_o      = r_cpl_qpn;
    assign cpl_bytes_o    = r_cpl_bytes;
    assign cpl_tag_o      = r_cpl_tag;
    assign cpl_err_o      = r_cpl_err;
    assign cpl_err_code_o = r_cpl_code;
    assign cpl_cnt_o      = r_cpl_cnt;
    assign err_cnt_o      = r_err_cnt;
    assign orphan_o       = r_orphan;
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_roce_stack_dm_status_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_roce_stack_dm_status_tracker
// Brief  : Randomised bench with queue-based reference model and scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_roce_stack_dm_status_tracker;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               aresetn_i = 1'b0;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_i = 1'b0;
    logic [103:0]       cmd_data_i = '0;
    logic [15:0]        cmd_qpn_i = '0;
    logic               cmd_allow_o;
    logic               sts_tvalid_i = 1'b0;
    logic               sts_tready_o;
    logic [7:0]         sts_tdata_i = '0;
    logic               sts_tkeep_i = 1'b0;
    logic               sts_tlast_i = 1'b0;
    logic               cpl_valid_o;
    logic               cpl_ready_i = 1'b1;
    logic [15:0]        cpl_qpn_o;
    logic [22:0]        cpl_bytes_o;
    logic [3:0]         cpl_tag_o;
    logic               cpl_err_o;
    logic [3:0]         cpl_err_code_o;
    logic [OW-1:0]      outstanding_o;
    logic [CNT_W-1:0]   cpl_cnt_o;
    logic [15:0]        err_cnt_o;
    logic               orphan_o;
    logic               err_o;
    logic               err_clr_i = 1'b0;

    always #5 clk = ~clk;

    roce_stack_dm_status_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .axis_aclk_i(clk), .aresetn_i(aresetn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_i(cmd_ready_i),
        .cmd_data_i(cmd_data_i), .cmd_qpn_i(cmd_qpn_i), .cmd_allow_o(cmd_allow_o),
        .sts_tvalid_i(sts_tvalid_i), .sts_tready_o(sts_tready_o),
        .sts_tdata_i(sts_tdata_i), .sts_tkeep_i(sts_tkeep_i), .sts_tlast_i(sts_tlast_i),
        .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i),
        .cpl_qpn_o(cpl_qpn_o), .cpl_bytes_o(cpl_bytes_o), .cpl_tag_o(cpl_tag_o),
        .cpl_err_o(cpl_err_o), .cpl_err_code_o(cpl_err_code_o),
        .outstanding_o(outstanding_o), .cpl_cnt_o(cpl_cnt_o), .err_cnt_o(err_cnt_o),
        .orphan_o(orphan_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    typedef struct { logic [3:0] tag; logic [22:0] btt; logic [15:0] qpn; } pend_s;
    typedef struct { logic [15:0] qpn; logic [22:0] bytes; logic [3:0] tag;
                     logic err; logic [3:0] code; } cpl_s;

    pend_s       pend_q[$];
    cpl_s        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_valid = 0;
    int unsigned m_cpl_cnt = 0;
    int          m_err_cnt = 0;
    bit          m_orphan = 0;
    bit          m_err = 0;
    bit          mon_en = 0;
    bit          just_reset = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard: evaluated mid-cycle, when inputs and
    // registered outputs are stable for the coming rising edge.
    always @(negedge clk) begin
        if (!aresetn_i) begin
            pend_q.delete();
            exp_q.delete();
            m_valid = 0; m_cpl_cnt = 0; m_err_cnt = 0; m_orphan = 0; m_err = 0;
            mon_en = 1; just_reset = 1;
        end else if (mon_en) begin
            int   size0;
            bit   exp_rdy, deliver, accept, orphan, del_err;
            cpl_s c;
            pend_s e;
            size0   = pend_q.size();
            exp_rdy = !m_valid || cpl_ready_i;
            chk("outstanding", 64'(outstanding_o), 64'(size0));
            chk("cmd_allow",   64'(cmd_allow_o),   64'(size0 < DEPTH));
            chk("cpl_valid",   64'(cpl_valid_o),   64'(m_valid));
            chk("sts_tready",  64'(sts_tready_o),  64'(exp_rdy));
            chk("cpl_cnt",     64'(cpl_cnt_o),     64'(m_cpl_cnt));
            chk("err_cnt",     64'(err_cnt_o),     64'(m_err_cnt));
            chk("orphan",      64'(orphan_o),      64'(m_orphan));
            chk("err_sticky",  64'(err_o),         64'(m_err));
            if (just_reset) begin
                chk("rst_cpl_data", 64'({cpl_qpn_o, cpl_bytes_o, cpl_tag_o, cpl_err_o, cpl_err_code_o}), 64'd0);
                just_reset = 0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'(1), 64'(0));
                end else begin
                    chk("cpl_qpn",   64'(cpl_qpn_o),      64'(exp_q[0].qpn));
                    chk("cpl_bytes", 64'(cpl_bytes_o),    64'(exp_q[0].bytes));
                    chk("cpl_tag",   64'(cpl_tag_o),      64'(exp_q[0].tag));
                    chk("cpl_err",   64'(cpl_err_o),      64'(exp_q[0].err));
                    chk("cpl_code",  64'(cpl_err_code_o), 64'(exp_q[0].code));
                end
            end

            deliver = m_valid && cpl_ready_i;
            del_err = 0;
            if (deliver) begin
                if (exp_q.size() != 0) begin
                    c = exp_q.pop_front();
                    del_err = c.err;
                end
                m_cpl_cnt++;
            end
            accept = sts_tvalid_i && exp_rdy;
            orphan = accept && (size0 == 0);
            if (accept && !orphan) begin
                e = pend_q.pop_front();
                c.qpn   = e.qpn;
                c.bytes = e.btt;
                c.tag   = sts_tdata_i[3:0];
                c.code  = {e.tag != sts_tdata_i[3:0], sts_tdata_i[6], sts_tdata_i[5], sts_tdata_i[4]};
                c.err   = (c.code != 4'd0) || !sts_tdata_i[7];
                exp_q.push_back(c);
                m_valid = 1;
            end else if (deliver) begin
                m_valid = 0;
            end
            if (cmd_valid_i && cmd_ready_i && size0 < DEPTH) begin
                e.tag = cmd_data_i[99:96];
                e.btt = cmd_data_i[22:0];
                e.qpn = cmd_qpn_i;
                pend_q.push_back(e);
            end
            m_err_cnt = m_err_cnt + int'(del_err) + int'(orphan);
            if (m_err_cnt > 65535) m_err_cnt = 65535;
            if (err_clr_i) begin
                m_orphan = 0; m_err = 0;
            end else begin
                if (orphan) m_orphan = 1;
                if (orphan || del_err) m_err = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cmd_valid_i = 0; sts_tvalid_i = 0; err_clr_i = 0;
    endtask

    task automatic set_cmd(input logic [3:0] tag, input logic [22:0] btt, input logic [15:0] qpn);
        cmd_data_i = {$urandom, $urandom, $urandom, $urandom};
        cmd_data_i[99:96] = tag;
        cmd_data_i[22:0]  = btt;
        cmd_qpn_i = qpn;
    endtask

    task automatic push_cmd(input logic [3:0] tag, input logic [22:0] btt, input logic [15:0] qpn);
        idle(); cmd_valid_i = 1; cmd_ready_i = 1; set_cmd(tag, btt, qpn);
        step(); idle();
    endtask

    task automatic send_sts(input logic [7:0] d);
        idle(); sts_tvalid_i = 1; sts_tdata_i = d;
        step(); idle();
    endtask

    task automatic rand_phase(input int n, input int p_cmd, input int p_sts, input int p_rdy);
        repeat (n) begin
            logic [3:0] t;
            cmd_ready_i  = ($urandom_range(99) < 80);
            cmd_valid_i  = cmd_allow_o && ($urandom_range(99) < p_cmd);
            set_cmd(4'($urandom), 23'($urandom), 16'($urandom));
            t = (pend_q.size() != 0 && $urandom_range(99) < 85) ? pend_q[0].tag : 4'($urandom);
            sts_tvalid_i = ($urandom_range(99) < p_sts);
            sts_tdata_i  = {($urandom_range(99) < 85), ($urandom_range(99) < 10),
                            ($urandom_range(99) < 10), ($urandom_range(99) < 10), t};
            sts_tkeep_i  = 1'($urandom);
            sts_tlast_i  = 1'($urandom);
            cpl_ready_i  = ($urandom_range(99) < p_rdy);
            err_clr_i    = ($urandom_range(99) < 3);
            step();
        end
        idle();
    endtask

    initial begin
        aresetn_i = 0; cpl_ready_i = 1;
        repeat (3) step();
        aresetn_i = 1;
        step();

        // Single OK completion, then SLVERR
        push_cmd(4'd3, 23'h1000, 16'h11);
        send_sts(8'h83);
        step(); step();
        push_cmd(4'd5, 23'h0222, 16'h22);
        send_sts(8'h45);
        step(); step();

        // Fill beyond depth; extra valids must be ignored
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmd_valid_i = 1; cmd_ready_i = 1;
            set_cmd(4'(i), 23'(i * 64), 16'(16'h100 + i));
            step();
        end
        idle(); step();
        send_sts({4'h8, pend_q[0].tag});
        step();

        // Back-pressure: completion held while statuses wait
        cpl_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            sts_tvalid_i = 1; sts_tdata_i = {4'h8, pend_q.size() != 0 ? pend_q[0].tag : 4'h0};
            step();
        end
        cpl_ready_i = 1;
        // Drain everything and keep going into orphans
        for (int i = 0; i < DEPTH + 4; i++) begin
            sts_tvalid_i = 1; sts_tdata_i = {4'h8, pend_q.size() != 0 ? pend_q[0].tag : 4'h0};
            step();
        end
        idle(); step();

        // Tag mismatch, then clear sticky flags
        push_cmd(4'd2, 23'h10, 16'h33);
        send_sts(8'h87);
        step();
        err_clr_i = 1; step(); idle(); step();

        rand_phase(600, 50, 50, 70);
        rand_phase(400, 80, 20, 40);
        rand_phase(400, 20, 80, 90);

        // Reset with entries pending; the next status is an orphan
        idle(); cpl_ready_i = 1;
        step(); step(); step();
        for (int i = 0; i < 4; i++) push_cmd(4'(i), 23'(i + 1), 16'(i + 7));
        aresetn_i = 0; step(); aresetn_i = 1; step();
        send_sts(8'h80);
        step();

        rand_phase(500, 50, 50, 60);
        idle(); cpl_ready_i = 1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/roce_stack_dm_status_tracker.md
Name: roce_stack_dm_status_tracker

Overview:
- Sits directly downstream of the AXI datamover status channels (MM2S or S2MM; one instance per channel). It replaces the tied-high status ready.
- Snoops each accepted 104-bit datamover command and records {tag, BTT, QPN} in an in-order pending FIFO.
- Pops one pending entry per 8-bit status beat and emits a completion record (QPN, bytes, error class) to the RoCE control path.
- Keeps sticky error and event counters for CSR readout.

Parameters:
- DEPTH, 16, pending-command FIFO entries; power of two, 2..64.
- CNT_W, 32, width of the completion counter.

Ports:
- axis_aclk_i  in  1  clock
- aresetn_i  in  1  synchronous active-low reset
- cmd_valid_i  in  1  datamover command valid (snooped)
- cmd_ready_i  in  1  datamover command ready (snooped)
- cmd_data_i  in  104  command word: [22:0] BTT, [95:32] addr, [99:96] tag
- cmd_qpn_i  in  16  QPN side-band, qualified with the command
- cmd_allow_o  out  1  upstream gate; the command requester must hold cmd_valid low while this is 0
- sts_tvalid_i  in  1  datamover status valid
- sts_tready_o  out  1  status ready
- sts_tdata_i  in  8  status: [3:0] tag, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
- sts_tkeep_i  in  1  ignored
- sts_tlast_i  in  1  ignored
- cpl_valid_o  out  1  completion valid
- cpl_ready_i  in  1  completion ready
- cpl_qpn_o  out  16  QPN of the completed command
- cpl_bytes_o  out  23  BTT of the completed command
- cpl_tag_o  out  4  tag carried in the status beat
- cpl_err_o  out  1  completion error
- cpl_err_code_o  out  4  {tag_mismatch, SLVERR, DECERR, INTERR}
- outstanding_o  out  $clog2(DEPTH)+1  pending FIFO occupancy
- cpl_cnt_o  out  CNT_W  completions delivered (wraps)
- err_cnt_o  out  16  erroneous completions plus orphans (saturates at 0xFFFF)
- orphan_o  out  1  sticky: status received while FIFO empty
- err_o  out  1  sticky: any error completion or orphan
- err_clr_i  in  1  clears orphan_o and err_o; err_clr_i wins over a same-cycle set

Behaviour:
- Reset (aresetn_i low at a clock edge):
  - FIFO pointers cleared; all pending entries dropped, including mid-operation.
  - cpl_valid_o = 0; all cpl_* data = 0; counters = 0; sticky flags = 0.
  - cmd_allow_o = 1; sts_tready_o = 1.
- Push:
  - Condition: cmd_valid_i & cmd_ready_i & cmd_allow_o.
  - Writes {cmd_data_i[99:96], cmd_data_i[22:0], cmd_qpn_i}.
- cmd_allow_o = !full. It is registered-state based: no same-cycle pop credit while full.
- Status acceptance:
  - sts_tready_o = !cpl_valid_o | cpl_ready_i (single output register, no skid buffer).
  - Accept = sts_tvalid_i & sts_tready_o.
- On accept with FIFO non-empty (occupancy taken before any same-cycle push):
  - Pop the head entry.
  - Next cycle: cpl_valid_o = 1; cpl_qpn_o and cpl_bytes_o from the entry; cpl_tag_o = sts_tdata_i[3:0].
  - cpl_err_code_o = {entry.tag != sts tag, sts[6], sts[5], sts[4]}.
  - cpl_err_o = |cpl_err_code_o | !sts[7].
  - Latency: exactly 1 cycle from status accept to cpl_valid_o.
- On accept with FIFO empty (orphan):
  - Beat consumed; no completion produced.
  - orphan_o and err_o set; err_cnt_o incremented.
- cpl_valid_o holds with stable data until cpl_ready_i.
  - Handshake cycle with a new status accept: cpl_valid_o stays 1 and the data is replaced.
  - Handshake cycle without a new accept: cpl_valid_o drops to 0.
- Counters update on completion delivery (cpl_valid_o & cpl_ready_i):
  - cpl_cnt_o increments.
  - If cpl_err_o, err_cnt_o increments (saturating) and err_o is set.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Tag mismatch: the entry is still popped (in-order assumption). The error is flagged; there is no resynchronisation.
- Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer MSB.

Decomposition:
- roceTypes package gains:
  - dm_sts_t: packed tag, interr, decerr, slverr, okay.
  - dm_cmd_t: 104-bit packed command view.
  - dm_pend_t: tag, btt, qpn.
  - DM_BTT_W = 23.
- One sub-module, roce_stack_sync_fifo (parameterised width/depth, full/empty/count); reusable across the stack.

Test Plan:
- Single OK: push cmd {tag=3, BTT=0x1000, qpn=0x11}, then status 0x83 -> next cycle cpl_valid_o=1, qpn=0x11, bytes=0x1000, err=0; cpl_cnt_o=1.
- SLVERR: push tag=5, status 0x45 -> cpl_err_o=1, code=4'b0100; err_o=1; err_cnt_o=1 after handshake.
- Full: push 16 commands with no status -> cmd_allow_o=0, outstanding_o=16. A 17th valid is ignored. One status -> cmd_allow_o=1 next cycle.
- Back-pressure: hold cpl_ready_i=0 with two statuses queued -> sts_tready_o=0 after the first; cpl data stable. Release -> both completions delivered in order on consecutive cycles.
- Orphan and mismatch:
  - Status 0x80 with FIFO empty -> orphan_o=1, no cpl_valid_o.
  - Push tag=2, status 0x87 -> code=4'b1000.
  - err_clr_i clears the sticky flags.
- Reset mid-operation: 4 pending entries, aresetn_i low for one cycle -> outstanding_o=0, cpl_valid_o=0, counters=0; a following status is treated as an orphan.
